// File: rtl/pattern_scan_scheduler.sv
// Round-robin scheduler sharing one serial 2-of-3 pattern detector among NREQ requesters.
// The granted word is shifted MSB-first, detector hits are counted, and the count is returned with the requester id.
module pattern_scan_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1),
    parameter int IW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  sched_en_i,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic                  det_enable_o,
    output logic                  det_serial_o,
    input  logic                  det_hit_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [IW-1:0]         resp_id_o,
    output logic [CW-1:0]         resp_count_o,
    output logic                  busy_o
);
    localparam int XW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, RESP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [IW-1:0]    id_q, id_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [XW-1:0]    idx_q, idx_d;

    logic             win_found;
    logic [IW-1:0]    win_id;
    logic [IW-1:0]    cand;
    logic             grant;
    logic [CW-1:0]    hit_inc;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(rr_ptr_q) + k) % NREQ);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign grant   = (state_q == IDLE) && sched_en_i && win_found;
    assign hit_inc = {{(CW-1){1'b0}}, det_hit_i};

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    word_d   = req_data_i[win_id*WIDTH +: WIDTH];
                    id_d     = win_id;
                    rr_ptr_d = win_id;
                    count_d  = '0;
                    idx_d    = XW'(WIDTH - 1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // The hit seen in the first shift cycle belongs to no bit of this word.
                if (idx_q != XW'(WIDTH - 1)) begin
                    count_d = count_q + hit_inc;
                end
                if (idx_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q - XW'(1);
                end
            end
            DRAIN: begin
                count_d = count_q + hit_inc;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= IDLE;
            word_q   <= '0;
            id_q     <= '0;
            rr_ptr_q <= IW'(NREQ - 1);
            count_q  <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
        end
    end

    // Grant strobe is combinational, so it is masked while reset is held.
    assign req_ready_o  = (grant && rstb) ? (NREQ'(1) << win_id) : '0;
    assign det_enable_o = (state_q == SHIFT);
    assign det_serial_o = det_enable_o & word_q[idx_q];
    assign resp_valid_o = (state_q == RESP);
    assign resp_id_o    = resp_valid_o ? id_q : '0;
    assign resp_count_o = resp_valid_o ? count_q : '0;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_pattern_scan_scheduler.sv
// Bench for pattern_scan_scheduler: a behavioural 2-of-3 detector and a job-timeline model checked every cycle,
// plus directed scenarios with hand-computed grant orders, counts and latencies.
module tb_pattern_scan_scheduler;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int IW    = $clog2(NREQ);

    logic                  clk;
    logic                  rstb;
    logic                  sched_en;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready_o;
    logic                  det_enable_o;
    logic                  det_serial_o;
    logic                  det_hit;
    logic                  resp_valid_o;
    logic                  resp_ready;
    logic [IW-1:0]         resp_id_o;
    logic [CW-1:0]         resp_count_o;
    logic                  busy_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    pattern_scan_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .sched_en_i   (sched_en),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready_o),
        .det_enable_o (det_enable_o),
        .det_serial_o (det_serial_o),
        .det_hit_i    (det_hit),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id_o),
        .resp_count_o (resp_count_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Detector: hit when exactly two of the last three bits are 1, once three bits have arrived since enable.
    logic [1:0] hist_q;
    int         nbits_q;
    logic       det_q;
    logic       prev_en_q;
    logic       inject_en;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hist_q    <= '0;
            nbits_q   <= 0;
            det_q     <= 1'b0;
            prev_en_q <= 1'b0;
        end else begin
            prev_en_q <= det_enable_o;
            if (!det_enable_o) begin
                hist_q  <= '0;
                nbits_q <= 0;
                det_q   <= 1'b0;
            end else begin
                hist_q  <= {hist_q[0], det_serial_o};
                nbits_q <= nbits_q + 1;
                det_q   <= (nbits_q >= 2) &&
                           (int'(hist_q[1]) + int'(hist_q[0]) + int'(det_serial_o) == 2);
            end
        end
    end

    // Spurious hits land only where the scheduler must ignore them (idle, response, first shift cycle).
    assign det_hit = det_q | (inject_en & ~prev_en_q);

    function automatic int pick(input int rr, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int count_pattern(input logic [WIDTH-1:0] wd);
        int n = 0;
        for (int i = WIDTH - 1; i >= 2; i--) begin
            if (int'(wd[i]) + int'(wd[i-1]) + int'(wd[i-2]) == 2) n++;
        end
        return n;
    endfunction

    // Job model: a grant starts a timeline of WIDTH shift cycles, one drain cycle, then response until accepted.
    bit               m_act = 1'b0;
    int               m_t   = 0;
    int               m_id  = 0;
    int               m_rr  = NREQ - 1;
    int               m_cnt = 0;
    logic [WIDTH-1:0] m_word = '0;
    int               w;
    logic [NREQ-1:0]  e_ready;
    logic             e_en, e_ser, e_rv, e_busy;
    logic [IW-1:0]    e_id;
    logic [CW-1:0]    e_cnt;

    int g_id[$], g_cyc[$], r_id[$], r_cnt[$], r_cyc[$], s_bits[$];

    always @(negedge clk) begin
        cyc++;
        e_ready = '0; e_en = 1'b0; e_ser = 1'b0; e_rv = 1'b0;
        e_id = '0; e_cnt = '0; e_busy = 1'b0;
        if (!rstb) begin
            m_act = 1'b0;
            m_rr  = NREQ - 1;
        end else if (!m_act) begin
            w = pick(m_rr, req_valid);
            if (sched_en && w >= 0) begin
                e_ready[w] = 1'b1;
                m_act  = 1'b1;
                m_t    = 1;
                m_id   = w;
                m_rr   = w;
                m_word = req_data[w*WIDTH +: WIDTH];
                m_cnt  = count_pattern(m_word);
            end
        end else begin
            e_busy = 1'b1;
            if (m_t <= WIDTH) begin
                e_en  = 1'b1;
                e_ser = m_word[WIDTH - m_t];
            end else if (m_t > WIDTH + 1) begin
                e_rv  = 1'b1;
                e_id  = IW'(m_id);
                e_cnt = CW'(m_cnt);
                if (resp_ready) m_act = 1'b0;
            end
            m_t++;
        end
        chk("req_ready", req_ready_o, e_ready);
        chk("det_enable", det_enable_o, e_en);
        chk("det_serial", det_serial_o, e_ser);
        chk("resp_valid", resp_valid_o, e_rv);
        chk("resp_id", resp_id_o, e_id);
        chk("resp_count", resp_count_o, e_cnt);
        chk("busy", busy_o, e_busy);
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready_o[i]) begin
                g_id.push_back(i);
                g_cyc.push_back(cyc);
            end
        end
        if (det_enable_o) s_bits.push_back(int'(det_serial_o));
        if (resp_valid_o && resp_ready) begin
            r_id.push_back(int'(resp_id_o));
            r_cnt.push_back(int'(resp_count_o));
            r_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        g_id.delete(); g_cyc.delete(); r_id.delete(); r_cnt.delete(); r_cyc.delete(); s_bits.delete();
    endtask

    task automatic wait_grants(input int n, input string name);
        for (int i = 0; i < 100; i++) begin
            if (g_id.size() >= n) break;
            tick();
        end
        chk(name, g_id.size() >= n, 1);
    endtask

    task automatic wait_resp(input int n, input string name);
        for (int i = 0; i < 200; i++) begin
            if (r_id.size() >= n) break;
            tick();
        end
        chk(name, r_id.size() >= n, 1);
    endtask

    int sv;

    initial begin
        rstb = 1'b0; sched_en = 1'b1; req_valid = '0; req_data = '0;
        resp_ready = 1'b1; inject_en = 1'b0;
        tick(3);
        chk("reset_outputs", {req_ready_o, det_enable_o, det_serial_o, resp_valid_o,
                              resp_id_o, resp_count_o, busy_o}, 0);
        rstb = 1'b1;
        tick(2);

        // Single job from requester 0
        clear_logs();
        req_data[0*WIDTH +: WIDTH] = 8'b0110_1100;
        req_valid[0] = 1'b1;
        wait_grants(1, "t1_grant_timeout");
        req_valid[0] = 1'b0;
        wait_resp(1, "t1_resp_timeout");
        tick(2);
        chk("t1_grant_count", g_id.size(), 1);
        chk("t1_grant_id", g_id[0], 0);
        chk("t1_resp_id", r_id[0], 0);
        chk("t1_resp_count", r_cnt[0], 5);
        chk("t1_latency", r_cyc[0] - g_cyc[0], 10);
        sv = 0;
        foreach (s_bits[i]) sv = sv * 2 + s_bits[i];
        chk("t1_serial_len", s_bits.size(), 8);
        chk("t1_serial_bits", sv, 8'h6C);

        // Back-to-back words from requester 2, with spurious hits injected where they must be ignored
        inject_en = 1'b1;
        clear_logs();
        req_data[2*WIDTH +: WIDTH] = 8'hFF;
        req_valid[2] = 1'b1;
        wait_grants(1, "t2_grant0_timeout");
        req_data[2*WIDTH +: WIDTH] = 8'h00;
        wait_grants(2, "t2_grant1_timeout");
        req_data[2*WIDTH +: WIDTH] = 8'b1010_1010;
        wait_grants(3, "t2_grant2_timeout");
        req_valid[2] = 1'b0;
        wait_resp(3, "t2_resp_timeout");
        chk("t2_cnt0", r_cnt[0], 0);
        chk("t2_cnt1", r_cnt[1], 0);
        chk("t2_cnt2", r_cnt[2], 3);
        chk("t2_ids", {r_id[0][3:0], r_id[1][3:0], r_id[2][3:0]}, 12'h222);
        chk("t2_spacing0", g_cyc[1] - g_cyc[0], 11);
        chk("t2_spacing1", g_cyc[2] - g_cyc[1], 11);

        // All requesters valid right after reset
        rstb = 1'b0;
        tick(2);
        rstb = 1'b1;
        clear_logs();
        req_data  = {8'hDB, 8'hFF, 8'hAA, 8'h6C};
        req_valid = 4'hF;
        wait_grants(5, "t3_grant_timeout");
        req_valid = '0;
        wait_resp(5, "t3_resp_timeout");
        chk("t3_grant_order", {g_id[0][3:0], g_id[1][3:0], g_id[2][3:0], g_id[3][3:0], g_id[4][3:0]}, 20'h01230);
        chk("t3_resp_ids", {r_id[0][3:0], r_id[1][3:0], r_id[2][3:0], r_id[3][3:0], r_id[4][3:0]}, 20'h01230);
        chk("t3_resp_counts", {r_cnt[0][3:0], r_cnt[1][3:0], r_cnt[2][3:0], r_cnt[3][3:0], r_cnt[4][3:0]}, 20'h53065);

        // Response stalled for 5 cycles with another request pending
        clear_logs();
        resp_ready = 1'b0;
        req_data[1*WIDTH +: WIDTH] = 8'hAA;
        req_data[3*WIDTH +: WIDTH] = 8'h6C;
        req_valid = 4'b1010;
        wait_grants(1, "t4_grant_timeout");
        req_valid[1] = 1'b0;
        chk("t4_first_winner", g_id[0], 1);
        for (int i = 0; i < 30; i++) begin
            if (resp_valid_o) break;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold", {resp_valid_o, resp_id_o, resp_count_o, busy_o, req_ready_o}, {1'b1, 2'd1, 4'd3, 1'b1, 4'b0000});
            tick();
        end
        resp_ready = 1'b1;
        wait_grants(2, "t4_grant2_timeout");
        req_valid = '0;
        chk("t4_second_winner", g_id[1], 3);
        chk("t4_grant_after_handshake", g_cyc[1] - r_cyc[0], 1);
        wait_resp(2, "t4_resp_timeout");
        chk("t4_second_count", r_cnt[1], 5);

        // Reset in the middle of a shift
        clear_logs();
        req_data[2*WIDTH +: WIDTH] = 8'hFF;
        req_valid[2] = 1'b1;
        wait_grants(1, "t5_grant_timeout");
        req_valid[2] = 1'b0;
        tick(3);
        req_data[1*WIDTH +: WIDTH] = 8'h6C;
        req_data[3*WIDTH +: WIDTH] = 8'hAA;
        req_valid = 4'b1010;
        rstb = 1'b0;
        #1;
        chk("t5_async_reset_outputs", {req_ready_o, det_enable_o, det_serial_o, resp_valid_o,
                                       resp_id_o, resp_count_o, busy_o}, 0);
        tick(2);
        rstb = 1'b1;
        wait_grants(2, "t5_grant2_timeout");
        req_valid = '0;
        chk("t5_rr_restart_winner", g_id[1], 1);
        wait_resp(1, "t5_resp_timeout");
        tick(3);
        chk("t5_no_aborted_resp", r_id.size(), 1);
        chk("t5_resp_id", r_id[0], 1);
        chk("t5_resp_count", r_cnt[0], 5);

        // Scheduler enable gating
        clear_logs();
        sched_en = 1'b0;
        req_data[0*WIDTH +: WIDTH] = 8'hAA;
        req_valid[0] = 1'b1;
        tick(4);
        chk("t6_no_grant_disabled", g_id.size(), 0);
        sched_en = 1'b1;
        #1;
        chk("t6_same_cycle_grant", req_ready_o, 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        req_data[2*WIDTH +: WIDTH] = 8'hFF;
        req_valid[2] = 1'b1;
        tick(3);
        sched_en = 1'b0;
        wait_resp(1, "t6_resp_timeout");
        tick(20);
        chk("t6_single_grant", g_id.size(), 1);
        chk("t6_resp", {r_id[0][3:0], r_cnt[0][3:0]}, 8'h03);
        chk("t6_idle_busy", busy_o, 0);
        req_valid = '0;
        sched_en  = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_scan_scheduler.md
Name: pattern_scan_scheduler

Overview:
Shares one serial 2-of-3 pattern detector among NREQ requesters. Each requester submits a WIDTH-bit word through a valid/ready handshake. Requesters are granted round-robin. The granted word is serialized MSB-first into the detector, and the block counts the detector's hit pulses. It returns the count and the requester id through a held valid/ready response. The block sits between the requester fabric and the detector, and owns the detector's enable and serial input.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 8, bits per word (3..64)
CW, $clog2(WIDTH+1), width of resp_count
IW, $clog2(NREQ), width of resp_id

Ports:
clk  in  1  clock
rstb  in  1  reset, asynchronous, active-low
sched_en  in  1  gates new grants; an in-flight job always completes
req_valid  in  NREQ  per-requester request valid
req_data  in  NREQ*WIDTH  word for requester i in bits [i*WIDTH +: WIDTH]
req_ready  out  NREQ  one-hot grant/accept strobe
det_enable  out  1  to detector enable (low clears detector history)
det_serial  out  1  to detector serial input
det_hit  in  1  detector registered output; a hit for bit k is seen the cycle after bit k is driven
resp_valid  out  1  result available
resp_ready  in  1  result consumed
resp_id  out  IW  requester index of the result
resp_count  out  CW  number of hits in the word
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rstb low, asynchronous): state=IDLE, rr_ptr=NREQ-1, all outputs 0. Reset mid-job abandons the job with no response, and det_enable drops immediately.
- FSM states are IDLE, SHIFT, DRAIN, RESP.
- IDLE:
  - If sched_en=1 and any req_valid is set, the winner is the first set bit searching from rr_ptr+1 upward, wrapping modulo NREQ.
  - req_ready[winner]=1 combinationally this cycle only.
  - At the clock edge the block latches word, id and count=0, sets rr_ptr=winner and bit index=WIDTH-1, then moves to SHIFT.
  - req_ready is 0 in every other state and whenever sched_en=0.
- SHIFT, WIDTH cycles:
  - det_enable=1; det_serial = word[idx], with idx running WIDTH-1 down to 0.
  - On every SHIFT cycle except the first, count += det_hit.
  - After the idx=0 cycle, go to DRAIN.
- DRAIN, 1 cycle: det_enable=0, det_serial=0, count += det_hit (this captures the hit for the last bit), then go to RESP.
- RESP:
  - resp_valid=1; resp_id and resp_count are held stable until resp_ready=1.
  - When resp_valid & resp_ready, go to IDLE.
  - No grant is issued in the handshake cycle.
- det_enable is 0 in IDLE, DRAIN and RESP. The detector therefore starts every job from its cleared state, and no history carries over between words.
- Latency: grant in cycle A, bits driven in A+1..A+WIDTH, resp_valid first asserted in A+WIDTH+2. The minimum grant-to-grant spacing is WIDTH+3 cycles.
- Counter: CW bits. It cannot overflow, because at most WIDTH-2 hits are possible.
- Ignored inputs: a det_hit in IDLE/RESP, or in the first SHIFT cycle, is ignored.
- Requester rules:
  - A requester deasserting req_valid before it is granted is legal and simply loses the slot.
  - req_data is sampled only in the grant cycle.
- sched_en falling during SHIFT/DRAIN/RESP has no effect on the current job; it only blocks the next grant.

Test Plan:
- Requester 0 only, word 8'b0110_1100 -> req_ready[0] pulses once; det_serial = 0,1,1,0,1,1,0,0; resp_id=0, resp_count=5, resp_valid 10 cycles after the grant.
- Words 8'hFF, 8'h00 and 8'b1010_1010 sent back-to-back from requester 2 -> counts 0, 0, 3. det_enable is low for at least 2 cycles between jobs.
- All 4 requesters valid continuously, starting after reset -> grant order 0,1,2,3,0. Each response carries the matching id and count.
- resp_ready held low for 5 cycles -> resp_valid, resp_id and resp_count stay stable, no new req_ready appears, busy=1; grant resumes in the cycle after the handshake.
- rstb asserted in the middle of SHIFT -> all outputs 0 asynchronously, no response produced. The next job from requester 1 gives the correct count, with the round-robin search starting at requester 0.
- sched_en=0 with requests pending -> no req_ready. Raising sched_en -> grant in the same cycle. Dropping sched_en mid-job -> the job completes and its response is delivered.
